// File: rtl/collision_event_if.sv
// Collision-event bundle between the object drawers / game_controller and collision_event_gen.
// master = event producer (collision_event_gen), slave = the side driving pixel requests.
interface collision_event_if #(
    parameter int CNT_W = 8
);
    logic             startOfFrame;
    logic             pause;
    logic             smileyDR;
    logic             borderBottomDR;
    logic             obstacleDR;
    // Event outputs are registered single-cycle pulses; no back-pressure exists.
    logic             collisionSmileyBorderBottom;
    logic             collisionSmileyObstacle;
    logic             collisionSmileyObstacleReal;
    logic [CNT_W-1:0] hit_total;
    logic [1:0]       fsm_state;

    modport master (
        input  startOfFrame, pause, smileyDR, borderBottomDR, obstacleDR,
        output collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal, hit_total, fsm_state
    );

    modport slave (
        output startOfFrame, pause, smileyDR, borderBottomDR, obstacleDR,
        input  collisionSmileyBorderBottom, collisionSmileyObstacle,
               collisionSmileyObstacleReal, hit_total, fsm_state
    );
endinterface

// File: rtl/collision_event_gen.sv
// Turns per-pixel smiley overlaps into one-cycle collision pulses with a frame-based re-arm cooldown.
// Optional saturating real-hit counter enabled by defining HIT_COUNTER_EN.
module collision_event_gen #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              reset,
    collision_event_if.master evt_if
);
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    localparam logic [CW-1:0] CF_LAST = CW'(COOLDOWN_FRAMES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CONTACT  = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;

    logic          sof, ov_b, ov_o;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] clean_q, clean_d, clean_inc;
    logic          bot_seen_q, bot_seen_d, obs_seen_q, obs_seen_d;
    logic          bot_q, bot_d, obs_q, obs_d, real_q, real_d;

    assign sof       = evt_if.startOfFrame;
    assign ov_b      = evt_if.smileyDR & evt_if.borderBottomDR;
    assign ov_o      = evt_if.smileyDR & evt_if.obstacleDR;
    assign clean_inc = clean_q + 1'b1;

    // Overlap in the SOF cycle belongs to the new frame, so SOF masks the old flag.
    always_comb begin
        bot_d      = 1'b0;
        obs_d      = 1'b0;
        bot_seen_d = 1'b0;
        obs_seen_d = 1'b0;
        if (!evt_if.pause) begin
            bot_d      = ov_b & (sof | ~bot_seen_q);
            obs_d      = ov_o & (sof | ~obs_seen_q);
            bot_seen_d = ov_b | (bot_seen_q & ~sof);
            obs_seen_d = ov_o | (obs_seen_q & ~sof);
        end
    end

    // Frame boundary is evaluated first against the ended frame, then the current overlap.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        real_d  = 1'b0;
        if (sof) begin
            case (state_q)
                ST_CONTACT: begin
                    if (!obs_seen_q) begin
                        clean_d = CW'(1);
                        state_d = (COOLDOWN_FRAMES == 1) ? ST_IDLE : ST_COOLDOWN;
                    end
                end
                ST_COOLDOWN: begin
                    clean_d = clean_inc;
                    if (clean_inc == CF_LAST) state_d = ST_IDLE;
                end
                default: ;
            endcase
        end
        if (ov_o) begin
            if (state_d == ST_IDLE) begin
                real_d  = 1'b1;
                state_d = ST_CONTACT;
                clean_d = '0;
            end else if (state_d == ST_COOLDOWN) begin
                state_d = ST_CONTACT;
                clean_d = '0;
            end
        end
        if (bot_d) begin
            state_d = ST_IDLE;
            clean_d = '0;
        end
        if (evt_if.pause) begin
            real_d  = 1'b0;
            state_d = ST_IDLE;
            clean_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clean_q    <= '0;
            bot_seen_q <= 1'b0;
            obs_seen_q <= 1'b0;
            bot_q      <= 1'b0;
            obs_q      <= 1'b0;
            real_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clean_q    <= clean_d;
            bot_seen_q <= bot_seen_d;
            obs_seen_q <= obs_seen_d;
            bot_q      <= bot_d;
            obs_q      <= obs_d;
            real_q     <= real_d;
        end
    end

    assign evt_if.collisionSmileyBorderBottom = bot_q;
    assign evt_if.collisionSmileyObstacle     = obs_q;
    assign evt_if.collisionSmileyObstacleReal = real_q;
    assign evt_if.fsm_state                   = state_q;

`ifdef HIT_COUNTER_EN
    logic [CNT_W-1:0] hit_q, hit_d;

    // A bottom pulse means a ball relaunch, which wins over a simultaneous real hit.
    always_comb begin
        hit_d = hit_q;
        if (bot_d) hit_d = '0;
        else if (real_d && (hit_q != {CNT_W{1'b1}})) hit_d = hit_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) hit_q <= '0;
        else       hit_q <= hit_d;
    end

    assign evt_if.hit_total = hit_q;
`else
    assign evt_if.hit_total = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_collision_event_gen.sv
// Directed bench for collision_event_gen (COOLDOWN_FRAMES=4); CNT_W=2 when HIT_COUNTER_EN is defined.
module tb_collision_event_gen;
`ifdef HIT_COUNTER_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    collision_event_if #(.CNT_W(CNT_W)) evt ();

    collision_event_gen #(.COOLDOWN_FRAMES(4), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .evt_if (evt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one pixel, then sample the registered result 1 ns after the edge.
    task automatic pix(input logic sof, input logic sm, input logic bb, input logic ob);
        evt.startOfFrame   = sof;
        evt.smileyDR       = sm;
        evt.borderBottomDR = bb;
        evt.obstacleDR     = ob;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        evt.pause = 1'b0;
        pix(0, 0, 0, 0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pix(0, 1, 1, 1);
        n_tests++;
        if (evt.collisionSmileyBorderBottom !== 1'b0) begin
            n_fail++; $display("FAIL reset_bottom: got %b expected 0", evt.collisionSmileyBorderBottom);
        end
        n_tests++;
        if (evt.collisionSmileyObstacle !== 1'b0) begin
            n_fail++; $display("FAIL reset_obstacle: got %b expected 0", evt.collisionSmileyObstacle);
        end
        n_tests++;
        if (evt.collisionSmileyObstacleReal !== 1'b0) begin
            n_fail++; $display("FAIL reset_real: got %b expected 0", evt.collisionSmileyObstacleReal);
        end
        n_tests++;
        if (evt.hit_total !== '0) begin
            n_fail++; $display("FAIL reset_hit_total: got %0d expected 0", evt.hit_total);
        end
        n_tests++;
        if (evt.fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", evt.fsm_state);
        end
        reset = 1'b0;
        pix(0, 0, 0, 0);
        n_tests++;
        if (evt.collisionSmileyObstacle !== 1'b0) begin
            n_fail++; $display("FAIL reset_after_obstacle: got %b expected 0", evt.collisionSmileyObstacle);
        end
    endtask

    task automatic test_single_contact();
        do_reset();
        pix(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            pix(0, 1, 0, 1);
            n_tests++;
            if (evt.collisionSmileyObstacle !== (i == 0)) begin
                n_fail++; $display("FAIL contact_obstacle px%0d: got %b expected %b", i, evt.collisionSmileyObstacle, (i == 0));
            end
            n_tests++;
            if (evt.collisionSmileyObstacleReal !== (i == 0)) begin
                n_fail++; $display("FAIL contact_real px%0d: got %b expected %b", i, evt.collisionSmileyObstacleReal, (i == 0));
            end
        end
        n_tests++;
        if (evt.fsm_state !== 2'd1) begin
            n_fail++; $display("FAIL contact_state: got %0d expected 1", evt.fsm_state);
        end
    endtask

    task automatic test_cooldown();
        logic [11:0] contact;
        int obs_cnt, real_cnt;
        contact = 12'b1000_0100_0111;
        do_reset();
        for (int f = 0; f < 12; f++) begin
            obs_cnt  = 0;
            real_cnt = 0;
            for (int p = 0; p < 8; p++) begin
                if (contact[f] && p >= 3 && p <= 5) pix(p == 0, 1, 0, 1);
                else                                pix(p == 0, 0, 0, 0);
                obs_cnt  += int'(evt.collisionSmileyObstacle);
                real_cnt += int'(evt.collisionSmileyObstacleReal);
            end
            n_tests++;
            if (obs_cnt !== int'(contact[f])) begin
                n_fail++; $display("FAIL cooldown_obstacle f%0d: got %0d expected %0d", f, obs_cnt, contact[f]);
            end
            n_tests++;
            if (real_cnt !== int'(f == 0 || f == 11)) begin
                n_fail++; $display("FAIL cooldown_real f%0d: got %0d expected %0d", f, real_cnt, (f == 0 || f == 11));
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pix(1, 0, 0, 0);
        pix(0, 1, 1, 1);
        n_tests++;
        if ({evt.collisionSmileyBorderBottom, evt.collisionSmileyObstacle, evt.collisionSmileyObstacleReal} !== 3'b111) begin
            n_fail++; $display("FAIL same_cycle_pulses: got %b%b%b expected 111", evt.collisionSmileyBorderBottom,
                               evt.collisionSmileyObstacle, evt.collisionSmileyObstacleReal);
        end
        n_tests++;
        if (evt.fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL same_cycle_state: got %0d expected 0", evt.fsm_state);
        end
        n_tests++;
        if (evt.hit_total !== '0) begin
            n_fail++; $display("FAIL same_cycle_hit_total: got %0d expected 0", evt.hit_total);
        end
    endtask

    task automatic test_pause();
        int pulses;
        do_reset();
        evt.pause = 1'b1;
        pulses = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < 8; p++) begin
                pix(p == 0, 1, 1, 1);
                pulses += int'(evt.collisionSmileyBorderBottom) + int'(evt.collisionSmileyObstacle)
                        + int'(evt.collisionSmileyObstacleReal);
            end
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++; $display("FAIL pause_pulses: got %0d expected 0", pulses);
        end
        n_tests++;
        if (evt.fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL pause_state: got %0d expected 0", evt.fsm_state);
        end
        evt.pause = 1'b0;
        pix(0, 1, 0, 1);
        n_tests++;
        if (evt.collisionSmileyObstacleReal !== 1'b1) begin
            n_fail++; $display("FAIL resume_real: got %b expected 1", evt.collisionSmileyObstacleReal);
        end
        n_tests++;
        if (evt.collisionSmileyObstacle !== 1'b1) begin
            n_fail++; $display("FAIL resume_obstacle: got %b expected 1", evt.collisionSmileyObstacle);
        end
    endtask

    task automatic test_sof_overlap_and_reset();
        do_reset();
        pix(1, 0, 0, 0);
        pix(0, 1, 0, 1);
        pix(0, 0, 0, 0);
        pix(1, 1, 0, 1);
        n_tests++;
        if (evt.collisionSmileyObstacle !== 1'b1) begin
            n_fail++; $display("FAIL sof_overlap_obstacle: got %b expected 1", evt.collisionSmileyObstacle);
        end
        n_tests++;
        if (evt.collisionSmileyObstacleReal !== 1'b0) begin
            n_fail++; $display("FAIL sof_overlap_real: got %b expected 0", evt.collisionSmileyObstacleReal);
        end
        pix(0, 1, 0, 1);
        n_tests++;
        if (evt.collisionSmileyObstacle !== 1'b0) begin
            n_fail++; $display("FAIL sof_overlap_repeat: got %b expected 0", evt.collisionSmileyObstacle);
        end
        reset = 1'b1;
        pix(0, 1, 0, 1);
        n_tests++;
        if ({evt.collisionSmileyBorderBottom, evt.collisionSmileyObstacle, evt.collisionSmileyObstacleReal} !== 3'b000) begin
            n_fail++; $display("FAIL midreset_outputs: got %b%b%b expected 000", evt.collisionSmileyBorderBottom,
                               evt.collisionSmileyObstacle, evt.collisionSmileyObstacleReal);
        end
        n_tests++;
        if (evt.fsm_state !== 2'd0) begin
            n_fail++; $display("FAIL midreset_state: got %0d expected 0", evt.fsm_state);
        end
        reset = 1'b0;
        pix(0, 1, 0, 1);
        n_tests++;
        if (evt.collisionSmileyObstacleReal !== 1'b1) begin
            n_fail++; $display("FAIL postreset_real: got %b expected 1", evt.collisionSmileyObstacleReal);
        end
    endtask

    task automatic test_counter();
`ifdef HIT_COUNTER_EN
        int exp_cnt;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            pix(0, 1, 0, 1);
            exp_cnt = (k < 3) ? k : 3;
            n_tests++;
            if (evt.collisionSmileyObstacleReal !== 1'b1) begin
                n_fail++; $display("FAIL counter_real hit%0d: got %b expected 1", k, evt.collisionSmileyObstacleReal);
            end
            n_tests++;
            if (evt.hit_total !== CNT_W'(exp_cnt)) begin
                n_fail++; $display("FAIL counter_value hit%0d: got %0d expected %0d", k, evt.hit_total, exp_cnt);
            end
            evt.pause = 1'b1;
            pix(0, 0, 0, 0);
            evt.pause = 1'b0;
        end
        pix(0, 1, 1, 0);
        n_tests++;
        if (evt.collisionSmileyBorderBottom !== 1'b1) begin
            n_fail++; $display("FAIL counter_bottom: got %b expected 1", evt.collisionSmileyBorderBottom);
        end
        n_tests++;
        if (evt.hit_total !== '0) begin
            n_fail++; $display("FAIL counter_clear: got %0d expected 0", evt.hit_total);
        end
`else
        do_reset();
        pix(0, 1, 0, 1);
        n_tests++;
        if (evt.collisionSmileyObstacleReal !== 1'b1) begin
            n_fail++; $display("FAIL tied_real: got %b expected 1", evt.collisionSmileyObstacleReal);
        end
        n_tests++;
        if (evt.hit_total !== '0) begin
            n_fail++; $display("FAIL tied_hit_total: got %0d expected 0", evt.hit_total);
        end
`endif
    endtask

    initial begin
        reset              = 1'b1;
        evt.pause          = 1'b0;
        evt.startOfFrame   = 1'b0;
        evt.smileyDR       = 1'b0;
        evt.borderBottomDR = 1'b0;
        evt.obstacleDR     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_contact();
        test_cooldown();
        test_same_cycle();
        test_pause();
        test_sof_overlap_and_reset();
        test_counter();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
